// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain carrying payload, destination register and
// write-enable, with per-stage valid, stall/bubble insertion, ranged flush and forwarding lookup.
module pipe_stage_chain #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RW     = 5,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CW     = 32,
  localparam int unsigned SW    = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic [RW-1:0]     in_rd,
  input  logic              in_wen,
  output logic              in_ready,
  input  logic [STAGES-1:0] stall,
  input  logic              flush_en,
  input  logic [SW-1:0]     flush_lvl,
  input  logic [RW-1:0]     q_rs,
  input  logic [RW-1:0]     q_rt,
  output logic              fwd_hit_a,
  output logic [SW-1:0]     fwd_stg_a,
  output logic [DW-1:0]     fwd_dat_a,
  output logic              fwd_hit_b,
  output logic [SW-1:0]     fwd_stg_b,
  output logic [DW-1:0]     fwd_dat_b,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [RW-1:0]     out_rd,
  output logic              out_we,
  output logic [CW-1:0]     cnt_stall,
  output logic [CW-1:0]     cnt_flush,
  output logic [CW-1:0]     cnt_retire
);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] hold;
  logic [CW-1:0]     cnt_stall_q, cnt_stall_d;
  logic [CW-1:0]     cnt_flush_q, cnt_flush_d;
  logic [CW-1:0]     cnt_retire_q, cnt_retire_d;

  // A stall bit freezes its own stage and every younger one.
  always_comb begin
    hold = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hold[i] = |(stall >> i);
    end
  end

  assign in_ready = ~hold[0];

  // Stage advance / bubble insertion; flush overrides hold on the killed range.
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      st_d[i] = st_q[i];
    end
    if (!hold[0]) begin
      st_d[0].valid = in_valid & ~flush_en;
      st_d[0].wen   = in_wen;
      st_d[0].rd    = in_rd;
      st_d[0].data  = in_data;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (!hold[i]) begin
        if (hold[i-1]) begin
          st_d[i] = '0;
        end else begin
          st_d[i] = st_q[i-1];
        end
      end
    end
    if (flush_en) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (i <= 32'(flush_lvl)) begin
          st_d[i].valid = 1'b0;
        end
      end
    end
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign out_data  = st_q[STAGES-1].data;
  assign out_rd    = st_q[STAGES-1].rd;
  assign out_we    = st_q[STAGES-1].valid & st_q[STAGES-1].wen & (st_q[STAGES-1].rd != '0);

  // Saturating event counters.
  always_comb begin
    cnt_stall_d  = cnt_stall_q;
    cnt_flush_d  = cnt_flush_q;
    cnt_retire_d = cnt_retire_q;
    if ((|stall) && (cnt_stall_q != '1)) cnt_stall_d = cnt_stall_q + CW'(1);
    if (flush_en && (cnt_flush_q != '1)) cnt_flush_d = cnt_flush_q + CW'(1);
    if (out_we && (cnt_retire_q != '1))  cnt_retire_d = cnt_retire_q + CW'(1);
  end

  assign cnt_stall  = cnt_stall_q;
  assign cnt_flush  = cnt_flush_q;
  assign cnt_retire = cnt_retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
      cnt_stall_q  <= '0;
      cnt_flush_q  <= '0;
      cnt_retire_q <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_q[i] <= st_d[i];
      end
      cnt_stall_q  <= cnt_stall_d;
      cnt_flush_q  <= cnt_flush_d;
      cnt_retire_q <= cnt_retire_d;
    end
  end

  // Youngest-first lookup: scanning oldest to youngest lets the smallest stage win.
  always_comb begin
    fwd_hit_a = 1'b0;
    fwd_stg_a = '0;
    fwd_dat_a = '0;
    fwd_hit_b = 1'b0;
    fwd_stg_b = '0;
    fwd_dat_b = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (st_q[i].valid && st_q[i].wen && (st_q[i].rd == q_rs) && (q_rs != '0)) begin
        fwd_hit_a = 1'b1;
        fwd_stg_a = SW'(i + 1);
        fwd_dat_a = st_q[i].data;
      end
      if (st_q[i].valid && st_q[i].wen && (st_q[i].rd == q_rt) && (q_rt != '0)) begin
        fwd_hit_b = 1'b1;
        fwd_stg_b = SW'(i + 1);
        fwd_dat_b = st_q[i].data;
      end
    end
  end

endmodule
